// File: rtl/pifo_reg_sched.sv
// pifo_reg_sched: sequencer in front of a pifo_reg instance.
//
// Purpose:
//   Arbitrates round-robin enqueue requests from NUM_PORTS ingress sources
//   against a dequeue request from the egress side. It issues one pifo_reg
//   operation at a time as a single-cycle insert or remove strobe. After each
//   strobe it waits SETTLE_CYCLES cycles so that pifo_reg can recompute its
//   min/max before the next decision. Dequeued rank/meta go back to the
//   egress side.
//
// Operation sequence:
//   IDLE decides.
//   ISSUE drives the strobe, plus enq_ready or deq_valid.
//   SETTLE waits SETTLE_CYCLES cycles.
//   Back-to-back operations are therefore 2+SETTLE_CYCLES cycles apart.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   enq_valid         per-port enqueue request (level)
//   enq_rank/meta     packed per-port rank/meta; port p at [p*W +: W]
//   enq_ready         one-hot grant pulse during ISSUE
//   deq_req           egress dequeue request (level)
//   deq_valid         one-cycle pulse with deq_rank/deq_meta
//   pifo_insert/remove, pifo_rank_in/meta_in    strobes and data to pifo_reg
//   pifo_rank_out/meta_out/valid_out/max_rank/num_entries
//                                               status from pifo_reg
//   drop_cnt/evict_cnt    overflow statistics (optional)
//
// Optional feature:
//   Define PIFO_SCHED_DROP_STATS_EN to build the saturating drop/evict
//   counters. If it is not defined, both counters are tied to zero.

module pifo_reg_sched #(
    parameter int NUM_PORTS     = 4,
    parameter int L2_REG_WIDTH  = 2,
    parameter int RANK_WIDTH    = 8,
    parameter int META_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_DEQ_BURST = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            enq_valid,
    input  logic [NUM_PORTS*RANK_WIDTH-1:0] enq_rank,
    input  logic [NUM_PORTS*META_WIDTH-1:0] enq_meta,
    output logic [NUM_PORTS-1:0]            enq_ready,
    input  logic                            deq_req,
    output logic                            deq_valid,
    output logic [RANK_WIDTH-1:0]           deq_rank,
    output logic [META_WIDTH-1:0]           deq_meta,
    output logic                            pifo_insert,
    output logic [RANK_WIDTH-1:0]           pifo_rank_in,
    output logic [META_WIDTH-1:0]           pifo_meta_in,
    output logic                            pifo_remove,
    input  logic [RANK_WIDTH-1:0]           pifo_rank_out,
    input  logic [META_WIDTH-1:0]           pifo_meta_out,
    input  logic                            pifo_valid_out,
    input  logic [RANK_WIDTH-1:0]           pifo_max_rank,
    input  logic [L2_REG_WIDTH:0]           pifo_num_entries,
    output logic [31:0]                     drop_cnt,
    output logic [31:0]                     evict_cnt
);

    localparam int PTR_W   = $clog2(NUM_PORTS);
    localparam int BURST_W = $clog2(MAX_DEQ_BURST + 1);
    localparam int SET_W   = $clog2(SETTLE_CYCLES);

    localparam logic [BURST_W-1:0]    BURST_MAX   = BURST_W'(MAX_DEQ_BURST);
    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [NUM_PORTS-1:0]  ONE_HOT0    = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [BURST_W-1:0] burst;
    logic [SET_W-1:0]   settle_cnt;

    // ---- decision stage (p0): combinational view of the IDLE cycle ----
    logic                  enq_ok_p0;
    logic                  deq_ok_p0;
    logic                  deq_win_p0;
    logic                  found_p0;
    logic [PTR_W-1:0]      cand_p0;
    logic [PTR_W-1:0]      win_port_p0;
    logic [RANK_WIDTH-1:0] win_rank_p0;
    logic [META_WIDTH-1:0] win_meta_p0;

    // First valid port at or after rr_ptr. The pointer addition wraps
    // naturally because NUM_PORTS is a power of two.
    always_comb begin
        found_p0    = 1'b0;
        cand_p0     = '0;
        win_port_p0 = rr_ptr;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_p0 = rr_ptr + PTR_W'(i);
            if (!found_p0 && enq_valid[cand_p0]) begin
                win_port_p0 = cand_p0;
                found_p0    = 1'b1;
            end
        end
    end

    assign win_rank_p0 = enq_rank[win_port_p0*RANK_WIDTH +: RANK_WIDTH];
    assign win_meta_p0 = enq_meta[win_port_p0*META_WIDTH +: META_WIDTH];
    assign enq_ok_p0   = |enq_valid;
    // Both the valid flag and the entry count must agree that the PIFO
    // holds something. This rules out any remove from an empty PIFO.
    assign deq_ok_p0   = deq_req & pifo_valid_out & (pifo_num_entries != '0);
    assign deq_win_p0  = deq_ok_p0 & (~enq_ok_p0 | (burst < BURST_MAX));

    // ---- issue/settle stage (p1): registered strobes and sequencing ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            burst        <= '0;
            settle_cnt   <= '0;
            enq_ready    <= '0;
            deq_valid    <= 1'b0;
            deq_rank     <= '0;
            deq_meta     <= '0;
            pifo_insert  <= 1'b0;
            pifo_rank_in <= '0;
            pifo_meta_in <= '0;
            pifo_remove  <= 1'b0;
        end else begin
            enq_ready   <= '0;
            deq_valid   <= 1'b0;
            pifo_insert <= 1'b0;
            pifo_remove <= 1'b0;
            case (state)
                IDLE: begin
                    // The burst counter only counts dequeues that overtake a
                    // waiting enqueue. With nothing pending it restarts.
                    if (!enq_ok_p0) begin
                        burst <= '0;
                    end
                    if (deq_win_p0) begin
                        deq_valid   <= 1'b1;
                        pifo_remove <= 1'b1;
                        deq_rank    <= pifo_rank_out;
                        deq_meta    <= pifo_meta_out;
                        if (enq_ok_p0) begin
                            burst <= burst + 1'b1;
                        end
                        state <= ISSUE;
                    end else if (enq_ok_p0) begin
                        enq_ready    <= ONE_HOT0 << win_port_p0;
                        pifo_insert  <= 1'b1;
                        pifo_rank_in <= win_rank_p0;
                        pifo_meta_in <= win_meta_p0;
                        rr_ptr       <= win_port_p0 + 1'b1;
                        burst        <= '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PIFO_SCHED_DROP_STATS_EN
    localparam logic [L2_REG_WIDTH:0] DEPTH = {1'b1, {L2_REG_WIDTH{1'b0}}};

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic full_p0;
    assign full_p0 = (pifo_num_entries == DEPTH);

    // The overflow outcome is classified from the status seen in the deciding
    // cycle. pifo_reg drops an incoming rank that is not below its current
    // maximum; otherwise it evicts that maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt  <= '0;
            evict_cnt <= '0;
        end else if (state == IDLE && enq_ok_p0 && !deq_win_p0 && full_p0) begin
            if (win_rank_p0 >= pifo_max_rank) begin
                drop_cnt <= sat_inc32(drop_cnt);
            end else begin
                evict_cnt <= sat_inc32(evict_cnt);
            end
        end
    end
`else
    assign drop_cnt  = '0;
    assign evict_cnt = '0;

    logic unused_stats;
    assign unused_stats = ^pifo_max_rank;
`endif

endmodule

// File: tb/tb_pifo_reg_sched.sv
// Testbench for pifo_reg_sched. It contains:
//   - a behavioural stand-in for pifo_reg (an unordered entry list),
//   - a transaction-level reference model that predicts every operation,
//   - a scoreboard monitor that compares each DUT strobe/pulse against the
//     predicted operation.
// Directed phases are followed by a randomized phase.

module tb_pifo_reg_sched;

    localparam int N       = 4;
    localparam int RW      = 8;
    localparam int MW      = 8;
    localparam int L2      = 2;
    localparam int DEPTH   = 4;
    localparam int MAXB    = 4;
    localparam int SPACING = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [N-1:0]      enq_valid = '0;
    logic [N*RW-1:0]   enq_rank = '0;
    logic [N*MW-1:0]   enq_meta = '0;
    logic [N-1:0]      enq_ready;
    logic              deq_req = 1'b0;
    logic              deq_valid;
    logic [RW-1:0]     deq_rank;
    logic [MW-1:0]     deq_meta;
    logic              pifo_insert;
    logic [RW-1:0]     pifo_rank_in;
    logic [MW-1:0]     pifo_meta_in;
    logic              pifo_remove;
    logic [RW-1:0]     pifo_rank_out = '0;
    logic [MW-1:0]     pifo_meta_out = '0;
    logic              pifo_valid_out = 1'b0;
    logic [RW-1:0]     pifo_max_rank = '0;
    logic [L2:0]       pifo_num_entries = '0;
    logic [31:0]       drop_cnt;
    logic [31:0]       evict_cnt;

    pifo_reg_sched #(
        .NUM_PORTS(N), .L2_REG_WIDTH(L2), .RANK_WIDTH(RW), .META_WIDTH(MW),
        .SETTLE_CYCLES(2), .MAX_DEQ_BURST(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_rank(enq_rank), .enq_meta(enq_meta),
        .enq_ready(enq_ready), .deq_req(deq_req),
        .deq_valid(deq_valid), .deq_rank(deq_rank), .deq_meta(deq_meta),
        .pifo_insert(pifo_insert), .pifo_rank_in(pifo_rank_in),
        .pifo_meta_in(pifo_meta_in), .pifo_remove(pifo_remove),
        .pifo_rank_out(pifo_rank_out), .pifo_meta_out(pifo_meta_out),
        .pifo_valid_out(pifo_valid_out), .pifo_max_rank(pifo_max_rank),
        .pifo_num_entries(pifo_num_entries),
        .drop_cnt(drop_cnt), .evict_cnt(evict_cnt)
    );

    typedef struct {
        logic [RW-1:0] rank;
        logic [MW-1:0] meta;
    } ent_t;

    typedef struct {
        int            cyc;
        bit            is_deq;
        int            port;
        logic [RW-1:0] rank;
        logic [MW-1:0] meta;
    } op_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Lowest rank wins; on equal ranks the oldest entry wins.
    function automatic int min_idx(input ent_t q[$]);
        int b = 0;
        for (int i = 1; i < q.size(); i++) if (q[i].rank < q[b].rank) b = i;
        return b;
    endfunction

    // Highest rank; on equal ranks the newest entry is chosen.
    function automatic int max_idx(input ent_t q[$]);
        int b = 0;
        for (int i = 1; i < q.size(); i++) if (q[i].rank >= q[b].rank) b = i;
        return b;
    endfunction

    // ---------------- pifo_reg stand-in ----------------
    ent_t env_q[$];
    ent_t env_e;
    int   env_k;

    always @(posedge clk) begin
        if (rst) begin
            env_q.delete();
        end else if (pifo_insert) begin
            env_e.rank = pifo_rank_in;
            env_e.meta = pifo_meta_in;
            if (env_q.size() < DEPTH) begin
                env_q.push_back(env_e);
            end else begin
                env_k = max_idx(env_q);
                if (env_e.rank < env_q[env_k].rank) begin
                    env_q.delete(env_k);
                    env_q.push_back(env_e);
                end
            end
        end else if (pifo_remove) begin
            chk("remove_nonempty", 64'(env_q.size() != 0), 64'd1);
            if (env_q.size() != 0) env_q.delete(min_idx(env_q));
        end
        if (env_q.size() != 0) begin
            env_k = min_idx(env_q);
            pifo_rank_out <= env_q[env_k].rank;
            pifo_meta_out <= env_q[env_k].meta;
            pifo_max_rank <= env_q[max_idx(env_q)].rank;
        end else begin
            pifo_rank_out <= '0;
            pifo_meta_out <= '0;
            pifo_max_rank <= '0;
        end
        pifo_valid_out   <= (env_q.size() != 0);
        pifo_num_entries <= 3'(env_q.size());
    end

    // ---------------- reference model ----------------
    // The model works per transaction:
    //   - a decision is allowed every SPACING cycles,
    //   - a dequeue returns the minimum of the contents,
    //   - an enqueue is granted round-robin,
    //   - a dequeue may overtake a pending enqueue at most MAXB times in a row.
    ent_t   ref_q[$];
    op_t    sb[$];
    op_t    m_op;
    ent_t   m_e;
    int     cyc = 0;
    int     next_dec = 0;
    int     m_rr = 0;
    int     m_burst = 0;
    int     m_w;
    int     m_k;
    bit     m_eo;
    bit     m_dw;
    longint m_drop = 0;
    longint m_evict = 0;

    always @(posedge clk) begin
        if (rst) begin
            ref_q.delete();
            m_rr = 0; m_burst = 0; m_drop = 0; m_evict = 0;
            next_dec = cyc + 1;
        end else if (cyc >= next_dec) begin
            m_eo = |enq_valid;
            m_dw = deq_req && (ref_q.size() > 0) && (!m_eo || m_burst < MAXB);
            if (!m_eo) m_burst = 0;
            if (m_dw) begin
                m_k = min_idx(ref_q);
                m_op.cyc = cyc + 1; m_op.is_deq = 1'b1; m_op.port = -1;
                m_op.rank = ref_q[m_k].rank; m_op.meta = ref_q[m_k].meta;
                sb.push_back(m_op);
                ref_q.delete(m_k);
                if (m_eo) m_burst++;
                next_dec = cyc + SPACING;
            end else if (m_eo) begin
                m_w = -1;
                for (int i = 0; i < N; i++)
                    if (m_w < 0 && enq_valid[(m_rr + i) % N]) m_w = (m_rr + i) % N;
                m_e.rank = enq_rank[m_w*RW +: RW];
                m_e.meta = enq_meta[m_w*MW +: MW];
                m_op.cyc = cyc + 1; m_op.is_deq = 1'b0; m_op.port = m_w;
                m_op.rank = m_e.rank; m_op.meta = m_e.meta;
                sb.push_back(m_op);
                if (ref_q.size() < DEPTH) begin
                    ref_q.push_back(m_e);
                end else begin
                    m_k = max_idx(ref_q);
                    if (m_e.rank >= ref_q[m_k].rank) begin
                        m_drop++;
                    end else begin
                        m_evict++;
                        ref_q.delete(m_k);
                        ref_q.push_back(m_e);
                    end
                end
                m_rr = (m_w + 1) % N;
                m_burst = 0;
                next_dec = cyc + SPACING;
            end else begin
                next_dec = cyc + 1;
            end
        end
        cyc++;
    end

    // ---------------- scoreboard monitor ----------------
    op_t evlog[$];
    op_t mon_e;
    op_t mon_l;
    bit  mon_ev;
    int  mon_p;

    always @(negedge clk) begin
        mon_ev = pifo_insert | pifo_remove | deq_valid | (|enq_ready);
        if (mon_ev) begin
            chk("no_insert_and_remove", 64'(pifo_insert & pifo_remove), 64'd0);
            mon_p = -1;
            for (int i = 0; i < N; i++) if (enq_ready[i]) mon_p = i;
            mon_l.cyc = cyc; mon_l.is_deq = deq_valid; mon_l.port = mon_p;
            mon_l.rank = deq_valid ? deq_rank : pifo_rank_in;
            mon_l.meta = deq_valid ? deq_meta : pifo_meta_in;
            evlog.push_back(mon_l);
            if (sb.size() == 0) begin
                chk("unexpected_op", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("op_cycle", 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.is_deq) begin
                    chk("deq_valid", 64'(deq_valid), 64'd1);
                    chk("deq_remove", 64'(pifo_remove), 64'd1);
                    chk("deq_no_grant", 64'(enq_ready), 64'd0);
                    chk("deq_rank", 64'(deq_rank), 64'(mon_e.rank));
                    chk("deq_meta", 64'(deq_meta), 64'(mon_e.meta));
                end else begin
                    chk("enq_ready", 64'(enq_ready), 64'(4'b0001 << mon_e.port));
                    chk("enq_insert", 64'(pifo_insert), 64'd1);
                    chk("enq_no_deq", 64'(deq_valid), 64'd0);
                    chk("enq_rank_in", 64'(pifo_rank_in), 64'(mon_e.rank));
                    chk("enq_meta_in", 64'(pifo_meta_in), 64'(mon_e.meta));
                end
            end
        end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            chk("missed_op_at_cycle", 64'd0, 64'(mon_e.cyc));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_enq_ready"}, 64'(enq_ready), 64'd0);
        chk({tag, "_deq_valid"}, 64'(deq_valid), 64'd0);
        chk({tag, "_deq_rank"}, 64'(deq_rank), 64'd0);
        chk({tag, "_deq_meta"}, 64'(deq_meta), 64'd0);
        chk({tag, "_insert"}, 64'(pifo_insert), 64'd0);
        chk({tag, "_rank_in"}, 64'(pifo_rank_in), 64'd0);
        chk({tag, "_meta_in"}, 64'(pifo_meta_in), 64'd0);
        chk({tag, "_remove"}, 64'(pifo_remove), 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_evict_cnt"}, 64'(evict_cnt), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enq_valid = '0;
        deq_req = 1'b0;
        tick(2);
        check_zero("reset");
        rst = 1'b0;
        evlog.delete();
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int t = 0;
        while (evlog.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        chk({name, "_timeout"}, 64'(evlog.size() >= n), 64'd1);
    endtask

    task automatic set_enq(input int p, input logic [RW-1:0] r, input logic [MW-1:0] m);
        enq_valid[p] = 1'b1;
        enq_rank[p*RW +: RW] = r;
        enq_meta[p*MW +: MW] = m;
    endtask

    task automatic enq_one(input int p, input logic [RW-1:0] r, input logic [MW-1:0] m);
        int base = evlog.size();
        set_enq(p, r, m);
        wait_log(base + 1, 30, "enq_one");
        enq_valid[p] = 1'b0;
    endtask

    task automatic deq_n(input int n);
        int base = evlog.size();
        deq_req = 1'b1;
        wait_log(base + n, 10 * n + 10, "deq_n");
        deq_req = 1'b0;
    endtask

    task automatic chk_stats(input string tag);
`ifdef PIFO_SCHED_DROP_STATS_EN
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
        chk({tag, "_evict_cnt"}, 64'(evict_cnt), 64'(m_evict));
`else
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_evict_cnt"}, 64'(evict_cnt), 64'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Single enqueue, then spacing to the next operation.
        do_reset();
        set_enq(2, 8'h30, 8'hA5);
        wait_log(1, 20, "single");
        enq_valid = '0;
        if (evlog.size() >= 1) begin
            chk("single_port", 64'(evlog[0].port), 64'd2);
            chk("single_rank", 64'(evlog[0].rank), 64'h30);
            chk("single_meta", 64'(evlog[0].meta), 64'hA5);
        end
        set_enq(0, 8'h31, 8'h01);
        wait_log(2, 20, "single_next");
        enq_valid = '0;
        if (evlog.size() >= 2) chk("single_spacing", 64'(evlog[1].cyc - evlog[0].cyc), 64'd4);
        tick(6);

        // Round-robin fairness with all ports requesting.
        do_reset();
        set_enq(0, 8'h40, 8'h00);
        set_enq(1, 8'h30, 8'h01);
        set_enq(2, 8'h20, 8'h02);
        set_enq(3, 8'h10, 8'h03);
        wait_log(5, 40, "rr");
        enq_valid = '0;
        if (evlog.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_port", 64'(evlog[i].port), 64'(i % N));
            chk("rr_16_cycles", 64'(evlog[4].cyc - evlog[0].cyc), 64'd16);
        end
        tick(6);
        chk_stats("rr");

        // Rank order, then a held deq_req on an empty PIFO.
        do_reset();
        enq_one(1, 8'd9, 8'h90);
        enq_one(1, 8'd3, 8'h30);
        enq_one(1, 8'd7, 8'h70);
        base = evlog.size();
        deq_req = 1'b1;
        wait_log(base + 3, 40, "order");
        tick(24);
        chk("order_no_extra", 64'(evlog.size()), 64'(base + 3));
        deq_req = 1'b0;
        if (evlog.size() >= base + 3) begin
            chk("order_rank0", 64'(evlog[base].rank), 64'd3);
            chk("order_rank1", 64'(evlog[base + 1].rank), 64'd7);
            chk("order_rank2", 64'(evlog[base + 2].rank), 64'd9);
        end
        tick(6);

        // Dequeue bursts cannot starve an enqueue forever.
        do_reset();
        enq_one(3, 8'h50, 8'h05);
        enq_one(3, 8'h60, 8'h06);
        enq_one(3, 8'h70, 8'h07);
        enq_one(3, 8'h80, 8'h08);
        base = evlog.size();
        deq_req = 1'b1;
        set_enq(0, 8'h44, 8'h0A);
        wait_log(base + 6, 60, "starve");
        deq_req = 1'b0;
        enq_valid = '0;
        if (evlog.size() >= base + 6) begin
            for (int i = 0; i < 6; i++)
                chk("starve_kind", 64'(evlog[base + i].is_deq), 64'(i != 4));
            chk("starve_last_rank", 64'(evlog[base + 5].rank), 64'h44);
        end
        tick(8);

        // Overflow: one drop, one eviction.
        do_reset();
        enq_one(1, 8'd10, 8'h01);
        enq_one(1, 8'd20, 8'h02);
        enq_one(1, 8'd30, 8'h03);
        enq_one(1, 8'd40, 8'h04);
        enq_one(2, 8'd50, 8'h05);
        enq_one(2, 8'd5, 8'h06);
        tick(4);
`ifdef PIFO_SCHED_DROP_STATS_EN
        chk("ovf_drop_cnt", 64'(drop_cnt), 64'd1);
        chk("ovf_evict_cnt", 64'(evict_cnt), 64'd1);
`endif
        chk_stats("ovf");
        base = evlog.size();
        deq_n(4);
        if (evlog.size() >= base + 4) begin
            chk("ovf_deq0", 64'(evlog[base].rank), 64'd5);
            chk("ovf_deq1", 64'(evlog[base + 1].rank), 64'd10);
            chk("ovf_deq2", 64'(evlog[base + 2].rank), 64'd20);
            chk("ovf_deq3", 64'(evlog[base + 3].rank), 64'd30);
        end
        tick(6);

        // Reset during ISSUE.
        do_reset();
        set_enq(1, 8'h22, 8'h33);
        wait_log(1, 20, "midrst");
        rst = 1'b1;
        enq_valid = '0;
        tick(1);
        check_zero("midrst");
        rst = 1'b0;
        base = evlog.size();
        enq_one(2, 8'h12, 8'h34);
        deq_n(1);
        if (evlog.size() >= base + 2) begin
            chk("midrst_enq_port", 64'(evlog[base].port), 64'd2);
            chk("midrst_deq_rank", 64'(evlog[base + 1].rank), 64'h12);
            chk("midrst_deq_meta", 64'(evlog[base + 1].meta), 64'h34);
        end
        tick(6);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                if (enq_ready[p] && $urandom_range(0, 1) == 0) begin
                    enq_valid[p] = 1'b0;
                end else if (enq_ready[p] || (!enq_valid[p] && $urandom_range(0, 99) < 25)) begin
                    set_enq(p, RW'($urandom_range(0, 255)), MW'($urandom_range(0, 255)));
                end
            end
            deq_req = ($urandom_range(0, 99) < 45);
            tick(1);
        end
        enq_valid = '0;
        deq_req = 1'b0;
        tick(10);
        chk("rand_sb_drained", 64'(sb.size()), 64'd0);
        chk_stats("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
